// File: rtl/sd_spi_byte.sv
// rtl/sd_spi_byte.sv - SPI mode-0 byte engine shared by the CPU port and the SD DMA controller
module sd_spi_byte #(
   parameter int DIV_FAST = 1,
   parameter int DIV_SLOW = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cpu_start,
   input  logic [7:0] cpu_din,
   input  logic       sd_start,
   input  logic       slow,
   output logic       sd_rdy,
   output logic [7:0] sd_recvdata,
   output logic       sdclk,
   output logic       sdo,
   input  logic       sdi
);

   localparam int DIV_MAX = (DIV_FAST > DIV_SLOW) ? DIV_FAST : DIV_SLOW;
   localparam int CW      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
   localparam logic [CW-1:0] FAST_M1 = CW'(DIV_FAST - 1);
   localparam logic [CW-1:0] SLOW_M1 = CW'(DIV_SLOW - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t        state_q, state_d;
   logic [7:0]    tx_q, tx_d;
   logic [7:0]    rx_q, rx_d;
   logic [7:0]    recv_q, recv_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] lim_q, lim_d;
   logic [3:0]    h_q, h_d;
   logic          sclk_q, sclk_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         tx_q    <= '0;
         rx_q    <= '0;
         recv_q  <= 8'hFF;
         cnt_q   <= '0;
         lim_q   <= '0;
         h_q     <= '0;
         sclk_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         recv_q  <= recv_d;
         cnt_q   <= cnt_d;
         lim_q   <= lim_d;
         h_q     <= h_d;
         sclk_q  <= sclk_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      recv_d  = recv_q;
      cnt_d   = cnt_q;
      lim_d   = lim_q;
      h_d     = h_q;
      sclk_d  = sclk_q;
      case (state_q)
         IDLE: begin
            if (cpu_start || sd_start) begin
               // DMA requests always win and always transmit the 0xFF fill token
               tx_d    = sd_start ? 8'hFF : cpu_din;
               lim_d   = slow ? SLOW_M1 : FAST_M1;
               cnt_d   = '0;
               h_d     = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt_q == lim_q) begin
               cnt_d = '0;
               h_d   = h_q + 4'd1;
               if (!h_q[0]) begin
                  sclk_d = 1'b1;
                  rx_d   = {rx_q[6:0], sdi};
               end else if (h_q == 4'd15) begin
                  sclk_d  = 1'b0;
                  recv_d  = rx_q;
                  h_d     = '0;
                  state_d = IDLE;
               end else begin
                  sclk_d = 1'b0;
                  tx_d   = {tx_q[6:0], 1'b1};
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign sd_rdy      = (state_q == IDLE);
   assign sdclk       = sclk_q;
   assign sdo         = (state_q == SHIFT) ? tx_q[7] : 1'b1;
   assign sd_recvdata = recv_q;

endmodule
